// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mult_state_t;

    localparam int DEFAULT_WIDTH = 32;

    // The step counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/mult_step_counter.sv
// Loadable down-counter that tracks the remaining shift-add steps and flags the final one.
module mult_step_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int STEP_CNT_W = cnt_w(WIDTH);
    localparam logic [STEP_CNT_W-1:0] LOAD_VAL = STEP_CNT_W'(WIDTH);

    logic [STEP_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Qualified by en so the flag marks the step that takes the count to zero.
    assign last = en && (cnt == STEP_CNT_W'(1));

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential multiplier: one conditional add and right shift per clock for WIDTH steps.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    mult_state_t state;
    mult_state_t next_state;

    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] acc;
    logic [WIDTH:0]   hi_sum;
    logic [2*WIDTH:0] acc_next;
    logic             load;
    logic             step;
    logic             last;

    mult_step_counter #(
        .WIDTH(WIDTH)
    ) u_step_counter (
        .clk (clk),
        .rst (rst),
        .load(load),
        .en  (step),
        .last(last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The upper half keeps its carry so the add never overflows before the shift.
    always_comb begin
        hi_sum   = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand}) : acc[2*WIDTH:WIDTH];
        acc_next = {1'b0, hi_sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
        end else if (load) begin
            mcand <= op_a;
            acc   <= {1'b0, {WIDTH{1'b0}}, op_b};
        end else if (step) begin
            acc <= acc_next;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign product = acc[2*WIDTH-1:0];

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at WIDTH=32.
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int          tests_run;
    int          tests_failed;

    int          done_count;
    int          done_cyc [2];
    logic [63:0] done_prod [2];
    int          busy_drop;
    logic        busy_ok;

    shift_add_multiplier #(
        .WIDTH(32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called just after a negedge; the next posedge ends cycle 0.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
    endtask

    // Observes cycles 1..ncycles at the negedge, optionally pulsing start in chosen cycles.
    task automatic watchCycles(input int ncycles,
                               input int inj1, input logic [31:0] a1, input logic [31:0] b1,
                               input int inj2, input logic [31:0] a2, input logic [31:0] b2);
        done_count   = 0;
        busy_drop    = -1;
        busy_ok      = 1'b1;
        done_cyc[0]  = -1;
        done_cyc[1]  = -1;
        done_prod[0] = '0;
        done_prod[1] = '0;
        for (int c = 1; c <= ncycles; c++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (done_count == 0 && !busy) busy_ok = 1'b0;
            if (busy_drop < 0 && !busy) busy_drop = c;
            if (done) begin
                if (done_count < 2) begin
                    done_cyc[done_count]  = c;
                    done_prod[done_count] = product;
                end
                done_count++;
            end
            if (c == inj1) applyStimulus(a1, b1);
            if (c == inj2) applyStimulus(a2, b2);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start        = 1'b0;
        op_a         = '0;
        op_b         = '0;

        #1;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_product", product, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 3 x 5
        applyStimulus(32'd3, 32'd5);
        watchCycles(36, -1, '0, '0, -1, '0, '0);
        checkOutput("t1_done_count", 64'(done_count), 64'd1);
        checkOutput("t1_done_cycle", 64'(done_cyc[0]), 64'd33);
        checkOutput("t1_product", done_prod[0], 64'h0000_0000_0000_000F);
        checkOutput("t1_busy_calc", {63'd0, busy_ok}, 64'd1);
        checkOutput("t1_busy_drop", 64'(busy_drop), 64'd34);
        checkOutput("t1_product_hold", product, 64'h0000_0000_0000_000F);

        // All-ones squared exercises the carry on every add
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watchCycles(35, -1, '0, '0, -1, '0, '0);
        checkOutput("t2_done_cycle", 64'(done_cyc[0]), 64'd33);
        checkOutput("t2_product", done_prod[0], 64'hFFFF_FFFE_0000_0001);

        applyStimulus(32'hFFFF_FFFF, 32'd2);
        watchCycles(35, -1, '0, '0, -1, '0, '0);
        checkOutput("t2b_product", done_prod[0], 64'h0000_0001_FFFF_FFFE);

        // Zero operand still takes full latency
        applyStimulus(32'd0, 32'h1234_5678);
        watchCycles(35, -1, '0, '0, -1, '0, '0);
        checkOutput("t3_done_cycle", 64'(done_cyc[0]), 64'd33);
        checkOutput("t3_product", done_prod[0], 64'd0);

        // Start pulses in CALC and DONE are ignored; changed operands are not re-sampled
        applyStimulus(32'd7, 32'd9);
        watchCycles(75, 5, 32'd100, 32'd100, 33, 32'd11, 32'd13);
        checkOutput("t4_done_count", 64'(done_count), 64'd1);
        checkOutput("t4_done_cycle", 64'(done_cyc[0]), 64'd33);
        checkOutput("t4_product", done_prod[0], 64'd63);
        checkOutput("t4_busy_drop", 64'(busy_drop), 64'd34);

        // Reset in the middle of CALC
        applyStimulus(32'h8000_0000, 32'd2);
        watchCycles(10, -1, '0, '0, -1, '0, '0);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("t5_rst_done", {63'd0, done}, 64'd0);
        checkOutput("t5_rst_product", product, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        watchCycles(40, -1, '0, '0, -1, '0, '0);
        checkOutput("t5_no_done", 64'(done_count), 64'd0);
        applyStimulus(32'h8000_0000, 32'd2);
        watchCycles(35, -1, '0, '0, -1, '0, '0);
        checkOutput("t5_fresh_cycle", 64'(done_cyc[0]), 64'd33);
        checkOutput("t5_fresh_product", done_prod[0], 64'h0000_0001_0000_0000);

        // Back-to-back at the earliest legal restart
        applyStimulus(32'd2, 32'd3);
        watchCycles(72, 34, 32'd4, 32'd5, -1, '0, '0);
        checkOutput("t6_done_count", 64'(done_count), 64'd2);
        checkOutput("t6_first_cycle", 64'(done_cyc[0]), 64'd33);
        checkOutput("t6_first_product", done_prod[0], 64'd6);
        checkOutput("t6_second_cycle", 64'(done_cyc[1]), 64'd67);
        checkOutput("t6_second_product", done_prod[1], 64'd20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
